// File: rtl/rename_reg_file.sv
// Register-rename file: per logical register, committed data or an in-flight tag,
// with an internal tag allocator, multi-channel completion and registered read ports.
module rename_read_lane #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 64,
  parameter int NUM_CPL = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flash,
  input  logic [NUM_CPL-1:0]               hit,
  input  logic [NUM_CPL-1:0][DATA_W-1:0]   cpl_data,
  input  logic                             place,
  input  logic                             phys_valid,
  input  logic [DATA_W-1:0]                phys_data,
  input  logic [TAG_W-1:0]                 phys_tag,
  input  logic [DATA_W-1:0]                arch_data,
  output logic                             read_valid,
  output logic [DATA_W-1:0]                read_data,
  output logic [TAG_W-1:0]                 read_tag
);
  logic [DATA_W-1:0] byp;

  // descending scan so the lowest-index channel is the one left standing
  always_comb begin
    byp = '0;
    for (int c = NUM_CPL-1; c >= 0; c--)
      if (hit[c]) byp = cpl_data[c];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      read_data  <= '0;
      read_tag   <= '0;
    end else if (flash) begin
      read_valid <= 1'b0;
    end else if (|hit) begin
      read_valid <= 1'b1;
      read_data  <= byp;
    end else if (place) begin
      read_valid <= phys_valid;
      if (phys_valid) read_data <= phys_data;
      else            read_tag  <= phys_tag;
    end else begin
      read_valid <= 1'b1;
      read_data  <= arch_data;
    end
  end
endmodule

module rename_reg_file #(
  parameter int LOG_W   = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 64,
  parameter int NUM_RD  = 2,
  parameter int NUM_CPL = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flash,
  input  logic                             dest_en,
  input  logic [LOG_W-1:0]                 dest_logic,
  output logic [TAG_W-1:0]                 dest_tag,
  input  logic [NUM_RD-1:0][LOG_W-1:0]     src,
  output logic [NUM_RD-1:0]                read_valid,
  output logic [NUM_RD-1:0][DATA_W-1:0]    read_data,
  output logic [NUM_RD-1:0][TAG_W-1:0]     read_tag,
  input  logic [NUM_CPL-1:0]               cpl_en,
  input  logic [NUM_CPL-1:0][LOG_W-1:0]    cpl_logic,
  input  logic [NUM_CPL-1:0][TAG_W-1:0]    cpl_tag,
  input  logic [NUM_CPL-1:0][DATA_W-1:0]   cpl_data,
  output logic [NUM_CPL-1:0]               cpl_reject,
  input  logic                             cmt_en,
  input  logic [LOG_W-1:0]                 cmt_logic,
  input  logic [TAG_W-1:0]                 cmt_tag,
  input  logic [DATA_W-1:0]                cmt_data,
  output logic                             cmt_reject
);
  localparam int NREG = 1 << LOG_W;

  logic [NREG-1:0]              place, phys_valid;
  logic [NREG-1:0][DATA_W-1:0]  arch_data, phys_data;
  logic [NREG-1:0][TAG_W-1:0]   phys_tag;
  logic [TAG_W-1:0]             alloc;
  logic [NUM_CPL-1:0]           est;
  logic                         cmt_release;

  assign dest_tag   = alloc;
  assign cpl_reject = '0;
  assign cmt_reject = 1'b0;

  // a completion only lands on an entry still waiting on exactly that tag
  always_comb begin
    est = '0;
    for (int c = 0; c < NUM_CPL; c++)
      est[c] = !flash && cpl_en[c] && place[cpl_logic[c]] && !phys_valid[cpl_logic[c]]
               && (phys_tag[cpl_logic[c]] == cpl_tag[c]);
  end

  assign cmt_release = cmt_en && place[cmt_logic] && (phys_tag[cmt_logic] == cmt_tag)
                       && !(dest_en && dest_logic == cmt_logic);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      place      <= '0;
      phys_valid <= '0;
      phys_data  <= '0;
      phys_tag   <= '0;
      arch_data  <= '0;
      alloc      <= '0;
    end else begin
      if (cmt_en) arch_data[cmt_logic] <= cmt_data;
      if (flash) begin
        place <= '0;
        alloc <= '0;
      end else begin
        if (cmt_release) place[cmt_logic] <= 1'b0;
        for (int c = NUM_CPL-1; c >= 0; c--)
          if (est[c] && !(dest_en && dest_logic == cpl_logic[c])) begin
            phys_valid[cpl_logic[c]] <= 1'b1;
            phys_data[cpl_logic[c]]  <= cpl_data[c];
          end
        if (dest_en) begin
          place[dest_logic]      <= 1'b1;
          phys_valid[dest_logic] <= 1'b0;
          phys_tag[dest_logic]   <= alloc;
          alloc                  <= alloc + 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [NUM_CPL-1:0] hit;
    always_comb begin
      hit = '0;
      for (int c = 0; c < NUM_CPL; c++)
        hit[c] = est[c] && (cpl_logic[c] == src[r]);
    end

    rename_read_lane #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CPL(NUM_CPL)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .flash      (flash),
      .hit        (hit),
      .cpl_data   (cpl_data),
      .place      (place[src[r]]),
      .phys_valid (phys_valid[src[r]]),
      .phys_data  (phys_data[src[r]]),
      .phys_tag   (phys_tag[src[r]]),
      .arch_data  (arch_data[src[r]]),
      .read_valid (read_valid[r]),
      .read_data  (read_data[r]),
      .read_tag   (read_tag[r])
    );
  end
endmodule
